// File: rtl/offnariscv_pkg.sv
// Shared definitions for the core snoop controller: CRRESP bit positions,
// DVM snoop encodings, the snoop sequencer state type and the response merge.
// Pure definitions, no logic state.
package offnariscv_pkg;

  // CRRESP bit positions {WasUnique, IsShared, PassDirty, Error, DataTransfer}
  localparam int CRRESP_DT  = 0;
  localparam int CRRESP_ERR = 1;
  localparam int CRRESP_PD  = 2;
  localparam int CRRESP_IS  = 3;
  localparam int CRRESP_WU  = 4;

  // ACSNOOP encodings that are DVM traffic and never touch the caches
  localparam logic [3:0] ACSNOOP_DVM_CMPL = 4'b1110;
  localparam logic [3:0] ACSNOOP_DVM_MSG  = 4'b1111;

  typedef enum logic [2:0] {
    SNP_IDLE,
    SNP_ISSUE,
    SNP_WAIT,
    SNP_RESP,
    SNP_DATA
  } snoop_state_e;

  function automatic logic is_dvm(input logic [3:0] snoop);
    return (snoop == ACSNOOP_DVM_CMPL) || (snoop == ACSNOOP_DVM_MSG);
  endfunction

  // Merge the I-cache sharing/error flags with the full D-cache response.
  // The I-cache never holds dirty data, so only the D-cache may supply
  // PassDirty and DataTransfer.
  function automatic logic [4:0] merge_crresp(input logic       i_wu,
                                              input logic       i_is,
                                              input logic       i_err,
                                              input logic [4:0] d_resp);
    logic [4:0] m;
    m             = '0;
    m[CRRESP_WU]  = i_wu  | d_resp[CRRESP_WU];
    m[CRRESP_IS]  = i_is  | d_resp[CRRESP_IS];
    m[CRRESP_ERR] = i_err | d_resp[CRRESP_ERR];
    m[CRRESP_PD]  = d_resp[CRRESP_PD];
    m[CRRESP_DT]  = d_resp[CRRESP_DT];
    return m;
  endfunction

endpackage

// File: rtl/snoop_target_port.sv
// Per-cache snoop issue/response tracker: holds the request until accepted, then collects one response.
// Latency: request visible the cycle issue_en rises; response accepted from the cycle after request handshake.
// Backpressure: snp_valid held until snp_ready; rsp_ready high only between issue and response.
//
// Ports: clk/rst (sync, active-low); clr clears both flags (controller idle);
//   issue_en qualifies the request; snp_valid/snp_ready request handshake;
//   rsp_valid/rsp_ready response handshake; issued_nxt/done_nxt are the flag
//   values including this cycle's handshake; rsp_fire marks response capture.
module snoop_target_port (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic issue_en,
  output logic snp_valid,
  input  logic snp_ready,
  input  logic rsp_valid,
  output logic rsp_ready,
  output logic issued_nxt,
  output logic done_nxt,
  output logic rsp_fire
);

  logic issued_q;
  logic done_q;
  logic snp_fire;

  assign snp_valid  = issue_en & ~issued_q;
  assign snp_fire   = snp_valid & snp_ready;
  // A response is only taken once this cache has seen the request.
  assign rsp_ready  = issued_q & ~done_q;
  assign rsp_fire   = rsp_valid & rsp_ready;
  // Look-ahead values let the controller advance in the handshake cycle.
  assign issued_nxt = issued_q | snp_fire;
  assign done_nxt   = done_q | rsp_fire;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      issued_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      issued_q <= issued_nxt;
      done_q   <= done_nxt;
    end
  end

endmodule

// File: rtl/core_snoop_ctrl.sv
// ACE snoop sequencer: broadcasts one snoop to I/D caches, merges CRRESP, forwards the D line on CD.
// Latency: AC accept T -> cr_valid T+3 at best (T+1 for DVM); cd_valid the cycle after the CR handshake.
// Backpressure: one snoop in flight (ac_ready only in IDLE); cr/cd/snp valids held until their ready.
//
// Ports: clk, rst (sync, active-low); AC in (ac_valid/ac_ready/ac_addr/ac_snoop/ac_prot);
//   CR out (cr_valid/cr_ready/cr_resp); CD out (cd_valid/cd_ready/cd_data/cd_last);
//   per-cache request (snp_i/d_valid, snp_i/d_ready, shared snp_addr/snp_snoop);
//   per-cache response (rsp_i/d_valid, rsp_i/d_ready, rsp_i/d_resp, rsp_d_data).
// Build option: CORE_SNOOP_ICACHE_EN enables I-cache participation; without it
//   the I-cache ports are inert and the D-cache alone answers.
module core_snoop_ctrl
  import offnariscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ac_valid,
  output logic                  ac_ready,
  input  logic [ADDR_WIDTH-1:0] ac_addr,
  input  logic [3:0]            ac_snoop,
  input  logic [2:0]            ac_prot,
  output logic                  cr_valid,
  input  logic                  cr_ready,
  output logic [4:0]            cr_resp,
  output logic                  cd_valid,
  input  logic                  cd_ready,
  output logic [DATA_WIDTH-1:0] cd_data,
  output logic                  cd_last,
  output logic                  snp_i_valid,
  output logic                  snp_d_valid,
  input  logic                  snp_i_ready,
  input  logic                  snp_d_ready,
  output logic [ADDR_WIDTH-1:0] snp_addr,
  output logic [3:0]            snp_snoop,
  input  logic                  rsp_i_valid,
  input  logic                  rsp_d_valid,
  output logic                  rsp_i_ready,
  output logic                  rsp_d_ready,
  input  logic [4:0]            rsp_i_resp,
  input  logic [4:0]            rsp_d_resp,
  input  logic [DATA_WIDTH-1:0] rsp_d_data
);

  snoop_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            snoop_q;
  logic [2:0]            prot_q;
  logic [2:0]            i_flags_q;   // {WasUnique, IsShared, Error} from I-cache
  logic [4:0]            d_resp_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic in_idle;
  logic in_issue;
  logic ac_fire;
  logic issued_i_nxt, done_i_nxt, i_fire;
  logic issued_d_nxt, done_d_nxt, d_fire;
  logic [4:0] merged;

  assign in_idle  = (state_q == SNP_IDLE);
  assign in_issue = (state_q == SNP_ISSUE);
  // Gated by rst so nothing is accepted while reset is held.
  assign ac_ready = in_idle & rst;
  assign ac_fire  = ac_valid & ac_ready;

  snoop_target_port u_d_port (
    .clk        (clk),
    .rst        (rst),
    .clr        (in_idle),
    .issue_en   (in_issue),
    .snp_valid  (snp_d_valid),
    .snp_ready  (snp_d_ready),
    .rsp_valid  (rsp_d_valid),
    .rsp_ready  (rsp_d_ready),
    .issued_nxt (issued_d_nxt),
    .done_nxt   (done_d_nxt),
    .rsp_fire   (d_fire)
  );

`ifdef CORE_SNOOP_ICACHE_EN
  snoop_target_port u_i_port (
    .clk        (clk),
    .rst        (rst),
    .clr        (in_idle),
    .issue_en   (in_issue),
    .snp_valid  (snp_i_valid),
    .snp_ready  (snp_i_ready),
    .rsp_valid  (rsp_i_valid),
    .rsp_ready  (rsp_i_ready),
    .issued_nxt (issued_i_nxt),
    .done_nxt   (done_i_nxt),
    .rsp_fire   (i_fire)
  );
`else
  // I-cache absent: it counts as already issued and answered, so the
  // sequencer waits on the D-cache only and I flags stay clear.
  assign snp_i_valid  = 1'b0;
  assign rsp_i_ready  = 1'b0;
  assign issued_i_nxt = 1'b1;
  assign done_i_nxt   = 1'b1;
  assign i_fire       = 1'b0;

  logic unused_i_port;
  assign unused_i_port = ^{snp_i_ready, rsp_i_valid};
`endif

  // PassDirty/DataTransfer from the I-cache are meaningless; prot is only kept.
  logic unused_bits;
  assign unused_bits = ^{rsp_i_resp[CRRESP_DT], rsp_i_resp[CRRESP_PD], prot_q};

  assign merged = merge_crresp(i_flags_q[2], i_flags_q[1], i_flags_q[0], d_resp_q);

  always_comb begin
    state_d  = state_q;
    cr_valid = 1'b0;
    cd_valid = 1'b0;
    unique case (state_q)
      SNP_IDLE: begin
        if (ac_fire) state_d = is_dvm(ac_snoop) ? SNP_RESP : SNP_ISSUE;
      end
      SNP_ISSUE: begin
        if (issued_i_nxt && issued_d_nxt) state_d = SNP_WAIT;
      end
      SNP_WAIT: begin
        if (done_i_nxt && done_d_nxt) state_d = SNP_RESP;
      end
      SNP_RESP: begin
        cr_valid = 1'b1;
        if (cr_ready) state_d = merged[CRRESP_DT] ? SNP_DATA : SNP_IDLE;
      end
      SNP_DATA: begin
        cd_valid = 1'b1;
        if (cd_ready) state_d = SNP_IDLE;
      end
      default: state_d = SNP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= SNP_IDLE;
      addr_q    <= '0;
      snoop_q   <= '0;
      prot_q    <= '0;
      i_flags_q <= '0;
      d_resp_q  <= '0;
      data_q    <= '0;
    end else begin
      state_q <= state_d;
      // Clearing the response latches on accept makes a DVM answer zero.
      if (ac_fire) begin
        addr_q    <= ac_addr;
        snoop_q   <= ac_snoop;
        prot_q    <= ac_prot;
        i_flags_q <= '0;
        d_resp_q  <= '0;
      end
      if (i_fire) begin
        i_flags_q <= {rsp_i_resp[CRRESP_WU], rsp_i_resp[CRRESP_IS], rsp_i_resp[CRRESP_ERR]};
      end
      if (d_fire) begin
        d_resp_q <= rsp_d_resp;
        if (rsp_d_resp[CRRESP_DT]) data_q <= rsp_d_data;
      end
    end
  end

  assign cr_resp   = merged;
  assign cd_data   = data_q;
  assign cd_last   = cd_valid;
  assign snp_addr  = addr_q;
  assign snp_snoop = snoop_q;

endmodule

// File: doc/core_snoop_ctrl.md
# core_snoop_ctrl

Sequences ACE snoop traffic (AC/CR/CD channels) between the coherent interconnect and the core's two L1 caches (IFU I-cache, LSU D-cache). Accepts one snoop at a time, broadcasts it to both caches, collects and merges their responses into a single CRRESP, and forwards any returned line on CD. Sits beside the core's read/write arbiter at the core boundary, on the snoop half of the ACE port.

## Interface
- ADDR_WIDTH, 32, snoop address width
- DATA_WIDTH, 256, line width; one line is exactly one CD beat
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- ac_valid / ac_ready  in / out  1 / 1  snoop address handshake from interconnect
- ac_addr  in  ADDR_WIDTH  snooped line address
- ac_snoop  in  4  ACSNOOP
- ac_prot  in  3  ACPROT; captured, not interpreted
- cr_valid / cr_ready  out / in  1 / 1  snoop response handshake
- cr_resp  out  5  merged CRRESP {WasUnique, IsShared, PassDirty, Error, DataTransfer}
- cd_valid / cd_ready  out / in  1 / 1  snoop data handshake
- cd_data  out  DATA_WIDTH  line data; cd_last  out  1  tied 1 whenever cd_valid
- snp_i_valid, snp_d_valid  out  1  per-cache snoop request
- snp_i_ready, snp_d_ready  in  1  per-cache request accept
- snp_addr  out  ADDR_WIDTH  captured address, shared by both caches
- snp_snoop  out  4  captured ACSNOOP, shared
- rsp_i_valid, rsp_d_valid  in  1  per-cache response
- rsp_i_ready, rsp_d_ready  out  1  per-cache response accept
- rsp_i_resp, rsp_d_resp  in  5  per-cache CRRESP-format response
- rsp_d_data  in  DATA_WIDTH  D-cache line; valid with rsp_d_valid when rsp_d_resp[0]=1

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP, DATA.
- IDLE: ac_ready=1. On ac_valid: capture addr/snoop/prot. If ac_snoop is 4'b1110 or 4'b1111 (DVM) -> RESP with merged resp 5'b0, no cache dispatch. Otherwise -> ISSUE with issued/done flags cleared.
- ISSUE: snp_x_valid held per cache until snp_x_ready; set issued_x. Once both issued -> WAIT. A response may be collected in ISSUE for an already-issued cache.
- Response collection: rsp_x_ready = issued_x & ~done_x. On rsp_x_valid & rsp_x_ready: set done_x, latch resp (D also latches data if bit0=1).
- WAIT: both done -> RESP.
- Merge: Error, IsShared, WasUnique = OR of both. DataTransfer, PassDirty = D-cache bits only; I-cache bits 0 and 2 are discarded (I-cache never holds dirty data).
- RESP: cr_valid=1, cr_resp stable until cr_ready. Handshake -> DATA if merged DataTransfer=1, else IDLE.
- DATA: cd_valid=1, cd_last=1, cd_data = latched line; on cd_ready -> IDLE.
- Only one snoop outstanding; ac_ready=0 outside IDLE.

## Timing
- While rst=0: state IDLE; all valid/ready outputs 0; cr_resp, cd_data, snp_addr, snp_snoop, latches zero. First cycle after release: ac_ready=1.
- AC accepted cycle T: snp_x_valid from T+1. rsp_x_ready rises the cycle after snp_x handshake. Earliest cr_valid T+3 (both caches ready at T+1, respond at T+2). DVM: cr_valid at T+1.
- cd_valid earliest the cycle after the CR handshake; CD never precedes CR.
- Valid outputs never drop before their handshake; payloads stable while valid.
- Caches accepting/responding in different cycles: each tracked independently; no ordering between I and D.
- rsp_x_valid before issue: ignored (rsp_x_ready=0).
- Reset mid-snoop: abort to IDLE next edge, no CR/CD emitted; caches share the same reset.

## Configuration
- CORE_SNOOP_ICACHE_EN defined: I-cache participates as above.
- Undefined: I-cache ports remain; snp_i_valid=0, rsp_i_ready=0, issued_i/done_i forced 1 on entry to ISSUE; merged response comes from D-cache alone. Earliest cr_valid unchanged (T+3).

## Structure
- offnariscv_pkg: CRRESP bit index localparams (CRRESP_DT=0, _ERR=1, _PD=2, _IS=3, _WU=4), ACSNOOP DVM encodings, snoop FSM enum type.
- Sub-module snoop_target_port: per-cache issue/response handshake and issued/done flags; instantiated twice (I-port compiled out per macro).

## Test plan
- ReadShared addr 0x8000_0040, both caches ready immediately, I resp 5'b00000, D resp 5'b01000 -> cr_resp 5'b01000 at T+3, no CD, back to IDLE.
- CleanInvalid, D resp 5'b10101 with data 0xA5..A5, I resp 5'b00001 -> cr_resp 5'b10101, then cd_valid with 0xA5..A5, cd_last=1.
- DVM Message (ac_snoop 4'b1111) -> cr_valid at T+1, cr_resp 0, snp_x_valid never asserted.
- D snp_ready delayed 5 cycles, cr_ready/cd_ready low 3 cycles each -> all payloads held stable, ac_ready=0 throughout.
- rst=0 asserted in WAIT -> next cycle all outputs 0, no CR; after release new snoop completes normally.
- Build without CORE_SNOOP_ICACHE_EN, D resp 5'b01000 -> cr_resp 5'b01000, snp_i_valid stays 0.
